pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

- Parametrised elastic pipeline register; next generation of the fixed 32-bit IF/ID latch.
- Carries one DATA_W payload per beat with a valid bit and a valid/ready handshake. Supports stall, flush and enable, with a selectable stall/flush priority and an optional skid entry that registers the ready path.
- Placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); each instance is configured by parameters.

## Interface
- DATA_W, 32: payload width in bits (>=1).
- FLUSH_VAL, '0: payload value loaded on reset/flush (DATA_W bits).
- SKID, 0: 0 = single entry, combinational ready; 1 = main + skid entry, registered ready.
- STALL_OVER_FLUSH, 1: 1 = stall beats flush when both asserted; 0 = flush beats stall.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  enable; low = stage frozen.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage accepts a beat this cycle.
- in_data_i  in  DATA_W  upstream payload.
- stall_i  in  1  hold request from hazard unit.
- flush_i  in  1  discard request from branch/exception logic.
- out_valid_o  out  1  beat available downstream.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  payload of the main entry.
- count_o  out  2  occupied entries (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- State: main {valid, data}; skid {valid, data} only when SKID=1.
- Control priority per edge:
  - rst_i: both valids 0, both data FLUSH_VAL.
  - else !start_i: hold all state.
  - else resolve stall_i/flush_i per STALL_OVER_FLUSH.
  - Winning stall: hold all state.
  - Winning flush: valids 0, data FLUSH_VAL; the incoming beat is dropped.
  - Otherwise normal handshake.
- Handshake terms: accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- out_valid_o = main.valid & start_i & ~stall_i & ~rst_i. Downstream never pops a frozen or stalled stage.
- in_ready_o:
  - 0 whenever rst_i, !start_i, stall_i or flush_i.
  - Otherwise SKID=0: ~main.valid | out_ready_i (combinational through).
  - Otherwise SKID=1: ~skid.valid (registered only).
- SKID=0 normal update: if accept, main <= {1, in_data_i}; else if pop, main.valid <= 0.
- SKID=1 normal update:
  - pop & skid.valid: main <= skid; skid <= accept ? {1,in} : {0,hold data}.
  - pop & !skid.valid: main <= accept ? {1,in} : {0,hold data}.
  - !pop & accept & main.valid: skid <= {1,in}.
  - !pop & accept & !main.valid: main <= {1,in}.
- Ordering is strictly FIFO; skid never holds a beat while main is empty.
- count_o = main.valid + skid.valid.
- Data registers keep their value when the valid bit clears without a flush; no X leakage.

## Timing
- All outputs are reset to 0 except out_data_o = FLUSH_VAL.
- Latency 1 cycle: a beat accepted at edge N appears on out_data_o/out_valid_o after edge N.
- Throughput 1 beat/cycle with out_ready_i held high, both SKID modes.
- SKID=1 holds 2 beats under backpressure. in_ready_o drops the cycle after skid fills and rises the cycle after the first pop.
- Flush and simultaneous accept: flush wins; the beat is lost; upstream sees in_ready_o=0 that cycle.
- Stall and flush together: the STALL_OVER_FLUSH=1 result equals the IF/ID latch behaviour.
- Reset mid-stream discards all entries. The first accept is possible the cycle after rst_i falls, subject to start_i.
- start_i falling mid-stream freezes contents; transfer resumes unchanged when start_i rises.

## Structure
- Shared package pipe_pkg holds:
  - the default FLUSH_VAL constant (32'h0, the NOP encoding used by the IF/ID stage);
  - the localparams for the STALL_OVER_FLUSH encodings.
- A single module with a generate branch on SKID; no sub-module needed.
- One natural extraction: pipe_slot (valid+data register with load/clear/hold), instantiated once or twice.

## Test plan
- Reset: rst_i=1 two cycles with DATA_W=32, FLUSH_VAL=32'h13 -> out_valid_o=0, out_data_o=32'h13, count_o=0, in_ready_o=0.
- Streaming SKID=0: in_data_i 1,2,3,4 on consecutive cycles, out_ready_i=1 -> out_data_o 1,2,3,4 one cycle later, no bubbles.
- Backpressure SKID=1:
  - Stimulus: beats A,B,C offered, out_ready_i=0.
  - Required: A and B accepted, count_o=2, in_ready_o=0, C held upstream.
  - After out_ready_i=1: outputs A,B,C in order.
- Stall vs flush: main holds 32'hDEAD; stall_i=flush_i=1 for one cycle.
  - STALL_OVER_FLUSH=1: out_data_o stays 32'hDEAD, valid restored after stall.
  - STALL_OVER_FLUSH=0: valid=0, data=FLUSH_VAL.
- Enable gating: start_i=0 with in_valid_i=1 and out_ready_i=1 for 3 cycles -> no accept, no pop, count_o unchanged, out_valid_o=0.
- Flush with full skid: count_o=2, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, input beat dropped, in_ready_o=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the elastic pipeline register family.
//   PIPE_NOP          - default payload loaded on reset/flush (the IF/ID NOP encoding)
//   SOF_FLUSH_WINS    - STALL_OVER_FLUSH value: flush beats stall
//   SOF_STALL_WINS    - STALL_OVER_FLUSH value: stall beats flush
//   pipe_ctrl_t       - resolved per-edge control for one stage
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP       = 32'h0;
    localparam int          SOF_FLUSH_WINS = 0;
    localparam int          SOF_STALL_WINS = 1;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

    // Reduce simultaneous stall/flush requests to a single winner.
    function automatic pipe_ctrl_t resolve_ctrl(input logic stall, input logic flush,
                                                input int stall_over_flush);
        pipe_ctrl_t c;
        if (stall_over_flush == SOF_STALL_WINS) begin
            c.stall = stall;
            c.flush = flush & ~stall;
        end else begin
            c.flush = flush;
            c.stall = stall & ~flush;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data entry of the elastic pipeline register.
//   clk_i    clock
//   rst_i    synchronous active-high reset (valid=0, data=FLUSH_VAL)
//   clear_i  flush: same effect as reset
//   load_i   capture data_i and set valid
//   drop_i   clear valid only; data is kept so nothing undefined leaks out
//   data_i   payload to capture
//   valid_o  entry occupied
//   data_o   stored payload
module pipe_slot #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_o <= 1'b0;
            data_o  <= FLUSH_VAL;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (drop_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised elastic pipeline register with valid/ready
// handshake, stall, flush and enable.
//   DATA_W            payload width
//   FLUSH_VAL         payload loaded on reset/flush
//   SKID              0: single entry, ready combinational from out_ready_i
//                     1: main + skid entry, ready registered
//   STALL_OVER_FLUSH  1: stall wins over flush, 0: flush wins over stall
// Ports:
//   clk_i, rst_i (sync, active high), start_i (enable; low freezes stage)
//   in_valid_i / in_ready_o / in_data_i     upstream handshake
//   stall_i, flush_i                         hazard/branch control
//   out_valid_o / out_ready_i / out_data_o   downstream handshake
//   count_o                                  occupied entries
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W           = 32,
    parameter logic [DATA_W-1:0]  FLUSH_VAL        = DATA_W'(PIPE_NOP),
    parameter int                 SKID             = 0,
    parameter int                 STALL_OVER_FLUSH = SOF_STALL_WINS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    pipe_ctrl_t        ctrl;
    logic              normal;
    logic              clear;
    logic              accept;
    logic              pop;

    logic              m_valid;
    logic              m_load;
    logic              m_drop;
    logic [DATA_W-1:0] m_din;
    logic              s_valid;

    assign ctrl   = resolve_ctrl(stall_i, flush_i, STALL_OVER_FLUSH);
    // Any stall or flush request, even a losing one, blocks the handshake.
    assign normal = start_i & ~rst_i & ~stall_i & ~flush_i;
    assign clear  = start_i & ctrl.flush;

    assign out_valid_o = m_valid & start_i & ~stall_i & ~rst_i;
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign count_o     = {1'b0, m_valid} + {1'b0, s_valid};

    pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear),
        .load_i  (m_load),
        .drop_i  (m_drop),
        .data_i  (m_din),
        .valid_o (m_valid),
        .data_o  (out_data_o)
    );

    generate
        if (SKID == 0) begin : g_single
            assign s_valid    = 1'b0;
            assign in_ready_o = normal & (~m_valid | out_ready_i);

            always_comb begin
                m_din  = in_data_i;
                m_load = normal & accept;
                m_drop = normal & pop & ~accept;
            end
        end else begin : g_skid
            logic              s_load;
            logic              s_drop;
            logic [DATA_W-1:0] s_data;

            // Ready depends only on skid occupancy, never on out_ready_i.
            assign in_ready_o = normal & ~s_valid;

            pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clear_i (clear),
                .load_i  (s_load),
                .drop_i  (s_drop),
                .data_i  (in_data_i),
                .valid_o (s_valid),
                .data_o  (s_data)
            );

            always_comb begin
                m_load = 1'b0;
                m_drop = 1'b0;
                m_din  = in_data_i;
                s_load = 1'b0;
                s_drop = 1'b0;
                if (normal) begin
                    if (pop) begin
                        if (s_valid) begin
                            // Skid advances into main to preserve FIFO order.
                            m_load = 1'b1;
                            m_din  = s_data;
                            if (accept) s_load = 1'b1;
                            else        s_drop = 1'b1;
                        end else begin
                            if (accept) m_load = 1'b1;
                            else        m_drop = 1'b1;
                        end
                    end else if (accept) begin
                        // Fill main first so skid never holds a beat alone.
                        if (m_valid) s_load = 1'b1;
                        else         m_load = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int          W  = 32;
    localparam logic [31:0] FV = 32'h13;

    logic          clk = 1'b0;
    logic          rst_i, start_i, in_valid_i, stall_i, flush_i, out_ready_i;
    logic [W-1:0]  in_data_i;

    // a: SKID=0 stall-wins, b: SKID=1 stall-wins, c: SKID=0 flush-wins
    logic          rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c;
    logic [W-1:0]  dat_a, dat_b, dat_c;
    logic [1:0]    cnt_a, cnt_b, cnt_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .FLUSH_VAL(FV), .SKID(0), .STALL_OVER_FLUSH(1)) u_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(rdy_a), .in_data_i(in_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(vld_a), .out_ready_i(out_ready_i), .out_data_o(dat_a), .count_o(cnt_a));

    pipe_stage_reg #(.DATA_W(W), .FLUSH_VAL(FV), .SKID(1), .STALL_OVER_FLUSH(1)) u_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(rdy_b), .in_data_i(in_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(vld_b), .out_ready_i(out_ready_i), .out_data_o(dat_b), .count_o(cnt_b));

    pipe_stage_reg #(.DATA_W(W), .FLUSH_VAL(FV), .SKID(0), .STALL_OVER_FLUSH(0)) u_c (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(rdy_c), .in_data_i(in_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .out_valid_o(vld_c), .out_ready_i(out_ready_i), .out_data_o(dat_c), .count_o(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge and sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b1; in_valid_i = 1'b0; stall_i = 1'b0;
        flush_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;

        // Reset held two cycles
        tick(); tick();
        chk("rst_vld_a", {31'b0, vld_a}, 32'd0);
        chk("rst_dat_a", dat_a, FV);
        chk("rst_cnt_a", {30'b0, cnt_a}, 32'd0);
        chk("rst_rdy_a", {31'b0, rdy_a}, 32'd0);
        chk("rst_dat_b", dat_b, FV);
        chk("rst_rdy_b", {31'b0, rdy_b}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_rdy_a", {31'b0, rdy_a}, 32'd1);
        chk("post_rst_rdy_b", {31'b0, rdy_b}, 32'd1);

        // Streaming 1..4 with downstream always ready: no bubbles
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data_i = i;
            #1;
            chk("stream_rdy_a", {31'b0, rdy_a}, 32'd1);
            chk("stream_rdy_b", {31'b0, rdy_b}, 32'd1);
            tick();
            chk("stream_dat_a", dat_a, i);
            chk("stream_vld_a", {31'b0, vld_a}, 32'd1);
            chk("stream_dat_b", dat_b, i);
            chk("stream_vld_b", {31'b0, vld_b}, 32'd1);
        end
        in_valid_i = 1'b0;
        tick();
        chk("stream_drain_vld_a", {31'b0, vld_a}, 32'd0);
        chk("stream_drain_cnt_b", {30'b0, cnt_b}, 32'd0);

        // Backpressure on the skid variant: A,B accepted, C held
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA;
        tick();
        chk("bp_cnt1_b", {30'b0, cnt_b}, 32'd1);
        chk("bp_rdy1_b", {31'b0, rdy_b}, 32'd1);
        in_data_i = 32'hB;
        tick();
        chk("bp_cnt2_b", {30'b0, cnt_b}, 32'd2);
        chk("bp_rdy2_b", {31'b0, rdy_b}, 32'd0);
        in_data_i = 32'hC;
        tick();
        chk("bp_hold_cnt_b", {30'b0, cnt_b}, 32'd2);
        chk("bp_hold_dat_b", dat_b, 32'hA);
        chk("bp_hold_rdy_b", {31'b0, rdy_b}, 32'd0);
        out_ready_i = 1'b1;
        tick();
        chk("bp_out_B_b", dat_b, 32'hB);
        chk("bp_cnt_after_pop_b", {30'b0, cnt_b}, 32'd1);
        chk("bp_rdy_rise_b", {31'b0, rdy_b}, 32'd1);
        tick();
        chk("bp_out_C_b", dat_b, 32'hC);
        chk("bp_vld_C_b", {31'b0, vld_b}, 32'd1);
        in_valid_i = 1'b0;
        tick();
        chk("bp_empty_b", {30'b0, cnt_b}, 32'd0);

        // Stall and flush together on a held DEAD beat
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hDEAD;
        tick();
        in_valid_i = 1'b0;
        chk("sf_load_a", dat_a, 32'hDEAD);
        chk("sf_load_c", dat_c, 32'hDEAD);
        stall_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("sf_stalled_vld_a", {31'b0, vld_a}, 32'd0);
        chk("sf_rdy_a", {31'b0, rdy_a}, 32'd0);
        tick();
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("sf_stallwins_dat_a", dat_a, 32'hDEAD);
        chk("sf_stallwins_vld_a", {31'b0, vld_a}, 32'd1);
        chk("sf_flushwins_vld_c", {31'b0, vld_c}, 32'd0);
        chk("sf_flushwins_dat_c", dat_c, FV);
        chk("sf_flushwins_cnt_c", {30'b0, cnt_c}, 32'd0);

        // Enable gating: stage a holds DEAD, start low for 3 cycles
        start_i     = 1'b0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        in_data_i   = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en_rdy_a", {31'b0, rdy_a}, 32'd0);
            chk("en_vld_a", {31'b0, vld_a}, 32'd0);
            tick();
        end
        chk("en_cnt_a", {30'b0, cnt_a}, 32'd1);
        chk("en_dat_a", dat_a, 32'hDEAD);
        in_valid_i = 1'b0;
        start_i    = 1'b1;
        #1;
        chk("en_resume_vld_a", {31'b0, vld_a}, 32'd1);
        chk("en_resume_dat_a", dat_a, 32'hDEAD);

        // Flush with a full skid: beat dropped, stage empties
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h1;
        tick();
        in_data_i = 32'h2;
        tick();
        chk("fl_full_cnt_b", {30'b0, cnt_b}, 32'd2);
        flush_i   = 1'b1;
        in_data_i = 32'h3;
        #1;
        chk("fl_rdy_low_b", {31'b0, rdy_b}, 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_cnt_b", {30'b0, cnt_b}, 32'd0);
        chk("fl_vld_b", {31'b0, vld_b}, 32'd0);
        chk("fl_dat_b", dat_b, FV);
        chk("fl_rdy_b", {31'b0, rdy_b}, 32'd1);
        in_valid_i = 1'b0;

        // Reset mid-stream discards contents
        in_valid_i = 1'b1;
        in_data_i  = 32'h77;
        tick();
        in_valid_i = 1'b0;
        chk("mid_load_cnt_b", {30'b0, cnt_b}, 32'd1);
        do_reset();
        chk("mid_rst_cnt_b", {30'b0, cnt_b}, 32'd0);
        chk("mid_rst_dat_b", dat_b, FV);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
